// File: rtl/vx_ucode_sequencer_if.sv
// Instruction stream bundle between decode and ibuffer around the microcode
// sequencer: upstream macro-op handshake plus downstream uop handshake.
interface vx_ucode_sequencer_if #(
  parameter int DATAW     = 200,
  parameter int UPC_BITS  = 6,
  parameter int LOOP_BITS = 4
);
  logic                 in_valid;
  logic                 in_ready;
  logic                 in_ucode;
  logic [UPC_BITS-1:0]  in_entry;
  logic [LOOP_BITS-1:0] in_count;
  logic [DATAW-1:0]     in_data;

  logic                 out_valid;
  logic                 out_ready;
  logic [DATAW-1:0]     out_data;
  logic                 out_uop;
  logic                 out_last;

  modport master (
    output in_valid, in_ucode, in_entry, in_count, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_uop, out_last
  );

  modport slave (
    input  in_valid, in_ucode, in_entry, in_count, in_data, out_ready,
    output in_ready, out_valid, out_data, out_uop, out_last
  );
endinterface

// File: rtl/vx_ucode_sequencer.sv
// Microcode expander: non-microcoded instructions pass straight through,
// microcoded macro-ops are expanded into uops read from a writable table.
// Each entry is {ubr[1:0], next_upc, body}; the macro-op tag is prepended
// to every body to form the uop word.
module vx_ucode_sequencer #(
  parameter int DEPTH     = 64,
  parameter int TAG_W     = 40,
  parameter int DATAW     = 200,
  parameter int LOOP_BITS = 4
) (
  input  logic                                          clk,
  input  logic                                          reset,
  vx_ucode_sequencer_if.slave                           bus,
  input  logic                                          flush,
  output logic                                          busy,
  input  logic                                          cfg_we,
  input  logic [$clog2(DEPTH)-1:0]                      cfg_addr,
  input  logic [2+$clog2(DEPTH)+(DATAW-TAG_W)-1:0]      cfg_data,
  output logic                                          err
);
  localparam int UPC_BITS = $clog2(DEPTH);
  localparam int BODY_W   = DATAW - TAG_W;
  localparam int ENTRY_W  = 2 + UPC_BITS + BODY_W;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  localparam logic [1:0] UBR_FINISH = 2'b00;
  localparam logic [1:0] UBR_JUMP   = 2'b01;
  localparam logic [1:0] UBR_LOOP   = 2'b10;
  localparam logic [1:0] UBR_RSVD   = 2'b11;

  logic [ENTRY_W-1:0]   ucode_mem [DEPTH];
  logic [0:0]           state_r;
  logic [UPC_BITS-1:0]  upc_r;
  logic [LOOP_BITS-1:0] cnt_r;
  logic [TAG_W-1:0]     tag_r;

  logic [ENTRY_W-1:0]   cur_entry;
  logic [1:0]           cur_ubr;
  logic [UPC_BITS-1:0]  cur_next;
  logic [BODY_W-1:0]    cur_body;
  logic [UPC_BITS-1:0]  upc_inc;
  logic [1:0]           inc_ubr;
  logic                 in_fire;
  logic                 seq_fire;

  assign cur_entry = ucode_mem[upc_r];
  assign cur_ubr   = cur_entry[ENTRY_W-1 -: 2];
  assign cur_next  = cur_entry[BODY_W +: UPC_BITS];
  assign cur_body  = cur_entry[BODY_W-1:0];
  assign upc_inc   = (upc_r == UPC_BITS'(DEPTH - 1)) ? '0 : upc_r + UPC_BITS'(1);
  assign inc_ubr   = ucode_mem[upc_inc][ENTRY_W-1 -: 2];
  assign busy      = (state_r == SEQ);

  // Handshake and output mux; in SEQ the outputs depend only on registered state.
  // A flush in IDLE also holds off the pass-through so no word is delivered
  // downstream without being accepted upstream.
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = bus.in_data;
    bus.out_uop   = 1'b0;
    bus.out_last  = 1'b1;
    if (state_r == IDLE) begin
      if (bus.in_ucode) begin
        bus.in_ready = ~flush;
      end else begin
        bus.in_ready  = bus.out_ready & ~flush;
        bus.out_valid = bus.in_valid & ~flush;
      end
    end else begin
      bus.out_valid = 1'b1;
      bus.out_data  = {tag_r, cur_body};
      bus.out_uop   = 1'b1;
      bus.out_last  = (cur_ubr == UBR_FINISH) || (cur_ubr == UBR_RSVD) ||
                      ((cur_ubr == UBR_LOOP) && (cnt_r == '0) && (inc_ubr == UBR_FINISH));
    end
  end

  assign in_fire  = (state_r == IDLE) && bus.in_valid && bus.in_ucode && !flush;
  assign seq_fire = (state_r == SEQ) && bus.out_ready;

  // Sequencer state: latch a macro-op, then walk the table one uop per accepted beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      upc_r   <= '0;
      cnt_r   <= '0;
      tag_r   <= '0;
      err     <= 1'b0;
    end else begin
      err <= 1'b0;
      if (flush) begin
        state_r <= IDLE;
      end else if (in_fire) begin
        state_r <= SEQ;
        upc_r   <= bus.in_entry;
        cnt_r   <= bus.in_count;
        tag_r   <= bus.in_data[DATAW-1 -: TAG_W];
      end else if (seq_fire) begin
        case (cur_ubr)
          UBR_JUMP: upc_r <= cur_next;
          UBR_LOOP: begin
            if (cnt_r != '0) begin
              cnt_r <= cnt_r - LOOP_BITS'(1);
              upc_r <= cur_next;
            end else begin
              upc_r <= upc_inc;
            end
          end
          UBR_RSVD: begin
            state_r <= IDLE;
            err     <= 1'b1;
          end
          default: state_r <= IDLE;
        endcase
      end
    end
  end

  // Microcode table: writes land at the edge, so a same-cycle read sees old contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        ucode_mem[i] <= '0;
      end
    end else if (cfg_we) begin
      ucode_mem[cfg_addr] <= cfg_data;
    end
  end
endmodule

// File: tb/tb_vx_ucode_sequencer.sv
// Directed bench for the microcode sequencer: pass-through, linear and looped
// sequences, backpressure, flush, reserved branch, wrap and live table update.
module tb_vx_ucode_sequencer;
  localparam int DEPTH     = 64;
  localparam int TAG_W     = 40;
  localparam int DATAW     = 200;
  localparam int LOOP_BITS = 4;
  localparam int UPC_BITS  = 6;
  localparam int BODY_W    = DATAW - TAG_W;
  localparam int ENTRY_W   = 2 + UPC_BITS + BODY_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic                busy;
  logic                cfg_we;
  logic [UPC_BITS-1:0] cfg_addr;
  logic [ENTRY_W-1:0]  cfg_data;
  logic                err;

  vx_ucode_sequencer_if #(.DATAW(DATAW), .UPC_BITS(UPC_BITS), .LOOP_BITS(LOOP_BITS)) bus ();

  vx_ucode_sequencer #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATAW(DATAW), .LOOP_BITS(LOOP_BITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .flush    (flush),
    .busy     (busy),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .err      (err)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic [1:0]        m_ubr  [DEPTH];
  logic [BODY_W-1:0] m_body [DEPTH];
  int                exp_upc  [16];
  bit                exp_last [16];
  int                exp_n;
  logic [31:0]       rdy_pat;

  task automatic checkOutput(input string tag, input logic [DATAW-1:0] observed,
                             input logic [DATAW-1:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic cfgWrite(input int addr, input logic [1:0] ubr, input int nxt,
                          input logic [BODY_W-1:0] body);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_addr = UPC_BITS'(addr);
    cfg_data = {ubr, UPC_BITS'(nxt), body};
    @(posedge clk);
    #1;
    cfg_we       = 1'b0;
    m_ubr[addr]  = ubr;
    m_body[addr] = body;
  endtask

  task automatic applyStimulus(input int entry, input int count, input logic [TAG_W-1:0] tg);
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ucode = 1'b1;
    bus.in_entry = UPC_BITS'(entry);
    bus.in_count = LOOP_BITS'(count);
    bus.in_data  = {tg, 160'h5A5A_0000_1111_2222_3333_4444_5555_6666_7777_8888};
    #1;
    checkOutput("ucode_in_ready", DATAW'(bus.in_ready), DATAW'(1));
    checkOutput("ucode_bubble", DATAW'(bus.out_valid), DATAW'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_ucode = 1'b0;
  endtask

  task automatic runSeq(input logic [TAG_W-1:0] tg, input logic end_err);
    int k = 0;
    for (int c = 0; c < 64 && k < exp_n; c++) begin
      @(negedge clk);
      bus.out_ready = rdy_pat[c % 32];
      #1;
      checkOutput($sformatf("seq_valid[%0d]", k), DATAW'(bus.out_valid), DATAW'(1));
      checkOutput($sformatf("seq_uop[%0d]", k), DATAW'(bus.out_uop), DATAW'(1));
      checkOutput($sformatf("seq_busy[%0d]", k), DATAW'(busy), DATAW'(1));
      checkOutput($sformatf("seq_in_ready[%0d]", k), DATAW'(bus.in_ready), DATAW'(0));
      checkOutput($sformatf("seq_err[%0d]", k), DATAW'(err), DATAW'(0));
      checkOutput($sformatf("seq_data[%0d]", k), bus.out_data, {tg, m_body[exp_upc[k]]});
      checkOutput($sformatf("seq_last[%0d]", k), DATAW'(bus.out_last), DATAW'(exp_last[k]));
      if (bus.out_ready) k++;
    end
    checkOutput("seq_all_uops", DATAW'(k), DATAW'(exp_n));
    @(negedge clk);
    #1;
    checkOutput("seq_end_busy", DATAW'(busy), DATAW'(0));
    checkOutput("seq_end_valid", DATAW'(bus.out_valid), DATAW'(0));
    checkOutput("seq_end_err", DATAW'(err), DATAW'(end_err));
    rdy_pat = '1;
  endtask

  // Directed test sequence
  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      m_ubr[i]  = '0;
      m_body[i] = '0;
    end
    reset         = 1'b1;
    flush         = 1'b0;
    cfg_we        = 1'b0;
    cfg_addr      = '0;
    cfg_data      = '0;
    bus.in_valid  = 1'b0;
    bus.in_ucode  = 1'b0;
    bus.in_entry  = '0;
    bus.in_count  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    rdy_pat       = '1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", DATAW'(busy), DATAW'(0));
    checkOutput("reset_err", DATAW'(err), DATAW'(0));
    checkOutput("reset_valid", DATAW'(bus.out_valid), DATAW'(0));
    @(negedge clk);
    reset = 1'b0;

    // Pass-through
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_ucode = 1'b0;
    bus.in_data  = DATAW'(12'hABC);
    #1;
    checkOutput("pt_valid", DATAW'(bus.out_valid), DATAW'(1));
    checkOutput("pt_data", bus.out_data, DATAW'(12'hABC));
    checkOutput("pt_uop", DATAW'(bus.out_uop), DATAW'(0));
    checkOutput("pt_last", DATAW'(bus.out_last), DATAW'(1));
    checkOutput("pt_in_ready", DATAW'(bus.in_ready), DATAW'(1));
    bus.out_ready = 1'b0;
    #1;
    checkOutput("pt_backpressure", DATAW'(bus.in_ready), DATAW'(0));
    bus.out_ready = 1'b1;
    flush         = 1'b1;
    #1;
    checkOutput("pt_flush_in_ready", DATAW'(bus.in_ready), DATAW'(0));
    @(posedge clk);
    #1;
    flush        = 1'b0;
    bus.in_valid = 1'b0;

    // Linear sequence 0 -> 8 -> 9
    cfgWrite(0, 2'b01, 8, 160'h0);
    cfgWrite(8, 2'b01, 9, 160'h8);
    cfgWrite(9, 2'b00, 0, 160'h9);
    exp_n = 3;
    exp_upc[0] = 0; exp_upc[1] = 8; exp_upc[2] = 9;
    exp_last[0] = 0; exp_last[1] = 0; exp_last[2] = 1;
    applyStimulus(0, 0, 40'h12_3456_789A);
    runSeq(40'h12_3456_789A, 1'b0);

    // Counted loop 3,4,3,4,3,4,5
    cfgWrite(4, 2'b10, 3, 160'h44);
    cfgWrite(3, 2'b01, 4, 160'h33);
    cfgWrite(5, 2'b00, 0, 160'h55);
    exp_n = 7;
    exp_upc[0] = 3; exp_upc[1] = 4; exp_upc[2] = 3; exp_upc[3] = 4;
    exp_upc[4] = 3; exp_upc[5] = 4; exp_upc[6] = 5;
    exp_last[0] = 0; exp_last[1] = 0; exp_last[2] = 0; exp_last[3] = 0;
    exp_last[4] = 0; exp_last[5] = 1; exp_last[6] = 1;
    applyStimulus(3, 2, 40'hAB_CDEF_0123);
    runSeq(40'hAB_CDEF_0123, 1'b0);

    // Backpressure: ready 1,0,0,1 then held high
    exp_n = 3;
    exp_upc[0] = 0; exp_upc[1] = 8; exp_upc[2] = 9;
    exp_last[0] = 0; exp_last[1] = 0; exp_last[2] = 1;
    rdy_pat = 32'hFFFF_FFF9;
    applyStimulus(0, 0, 40'h77_0000_0077);
    runSeq(40'h77_0000_0077, 1'b0);

    // Flush on the second uop, then a fresh macro-op from its own entry
    applyStimulus(0, 0, 40'h55_5555_5555);
    @(negedge clk);
    bus.out_ready = 1'b1;
    #1;
    checkOutput("fl_uop0", bus.out_data, {40'h55_5555_5555, m_body[0]});
    @(negedge clk);
    bus.out_ready = 1'b0;
    flush         = 1'b1;
    #1;
    checkOutput("fl_uop1", bus.out_data, {40'h55_5555_5555, m_body[8]});
    @(posedge clk);
    #1;
    flush         = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("fl_idle_busy", DATAW'(busy), DATAW'(0));
    checkOutput("fl_idle_valid", DATAW'(bus.out_valid), DATAW'(0));
    checkOutput("fl_no_err", DATAW'(err), DATAW'(0));
    exp_n = 3;
    exp_upc[0] = 3; exp_upc[1] = 4; exp_upc[2] = 5;
    exp_last[0] = 0; exp_last[1] = 1; exp_last[2] = 1;
    applyStimulus(3, 0, 40'h66_6666_6666);
    runSeq(40'h66_6666_6666, 1'b0);

    // Reserved branch: single uop, err pulse, back to IDLE
    cfgWrite(20, 2'b11, 0, 160'h20);
    exp_n = 1;
    exp_upc[0] = 20;
    exp_last[0] = 1;
    applyStimulus(20, 0, 40'h20_2020_2020);
    runSeq(40'h20_2020_2020, 1'b1);
    @(negedge clk);
    #1;
    checkOutput("rsvd_err_pulse_end", DATAW'(err), DATAW'(0));

    // Loop exit at the last entry wraps to entry 0
    cfgWrite(63, 2'b10, 10, 160'h63);
    exp_n = 4;
    exp_upc[0] = 63; exp_upc[1] = 0; exp_upc[2] = 8; exp_upc[3] = 9;
    exp_last[0] = 0; exp_last[1] = 0; exp_last[2] = 0; exp_last[3] = 1;
    applyStimulus(63, 0, 40'h63_6363_6363);
    runSeq(40'h63_6363_6363, 1'b0);

    // Rewrite the entry currently being presented
    applyStimulus(9, 0, 40'h99_9999_9999);
    @(negedge clk);
    bus.out_ready = 1'b0;
    cfg_we        = 1'b1;
    cfg_addr      = 6'd9;
    cfg_data      = {2'b00, 6'd0, 160'h99};
    #1;
    checkOutput("cfg_old_body", bus.out_data, {40'h99_9999_9999, m_body[9]});
    checkOutput("cfg_old_last", DATAW'(bus.out_last), DATAW'(1));
    @(posedge clk);
    #1;
    cfg_we    = 1'b0;
    m_body[9] = 160'h99;
    @(negedge clk);
    #1;
    checkOutput("cfg_new_body", bus.out_data, {40'h99_9999_9999, 160'h99});
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    #1;
    checkOutput("cfg_end_busy", DATAW'(busy), DATAW'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
